// File: rtl/cordic_rr_scheduler.sv
// rtl/cordic_rr_scheduler.sv - round-robin arbiter sharing one iterative CORDIC engine
// Each job runs IDLE -> LAUNCH -> WAIT -> RESP; a watchdog aborts jobs whose engine never finishes.
module cordic_rr_scheduler #(
  parameter int N       = 4,
  parameter int W       = 6,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_angle,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_x,
  output logic [W-1:0]   rsp_y,
  output logic           eng_start,
  output logic [W-1:0]   eng_angle,
  input  logic           eng_done,
  input  logic [W-1:0]   eng_x,
  input  logic [W-1:0]   eng_y,
  output logic           timeout_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Timer counts completed WAIT cycles, so the abort lands in the TIMEOUT-th WAIT cycle.
  localparam logic [7:0]    TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(N - 1);

  logic [1:0]    state;
  logic [7:0]    timer;
  logic [IW-1:0] last;
  logic [IW-1:0] sel;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;
  logic [W-1:0]  pick_angle;
  int            cand;

  // Scan last+1, last+2, ... wrapping at N; the first pending requester wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(last) + i;
      if (cand >= N) cand = cand - N;
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    pick_onehot = '0;
    for (int k = 0; k < N; k++) begin
      pick_onehot[k] = (pick_idx == IW'(k));
    end
    pick_angle = req_angle[int'(pick_idx)*W +: W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      last        <= LAST_INIT;
      sel         <= '0;
      gnt         <= '0;
      rsp_valid   <= '0;
      rsp_x       <= '0;
      rsp_y       <= '0;
      eng_start   <= 1'b0;
      eng_angle   <= '0;
      timeout_err <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            sel       <= pick_idx;
            gnt       <= pick_onehot;
            eng_angle <= pick_angle;
            eng_start <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving in the abort cycle still counts as a clean completion.
          if (eng_done) begin
            rsp_x     <= eng_x;
            rsp_y     <= eng_y;
            rsp_valid <= gnt;
            state     <= S_RESP;
          end else if (timer == TMO_LAST) begin
            rsp_x       <= '0;
            rsp_y       <= '0;
            rsp_valid   <= gnt;
            timeout_err <= 1'b1;
            state       <= S_RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        S_RESP: begin
          last  <= sel;
          gnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
